clint_timer: RTL and testbench



---
 rtl/clint_timer_if.sv | 14 +
 rtl/clint_timer.sv | 199 +++++++++++++++++++
 tb/tb_clint_timer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_timer_if.sv
// clint_timer_if: single-outstanding register bus between a bus master and the CLINT.
// The master holds ren/wen until busy drops; busy=0 marks the completing cycle.
interface clint_timer_if;
  logic [15:0] addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        busy;

  modport master (output addr, ren, wen, wdata, byte_en, input rdata, busy);
  modport slave  (input addr, ren, wen, wdata, byte_en, output rdata, busy);
endinterface

// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor with per-hart msip/mtimecmp, a shared
// prescaled 64-bit mtime, level timer/software interrupts and 1-cycle clear
// pulses on their falling edges.
// Optional feature: define CLINT_MTIME_HALT_EN to add the mtime_halt input,
// which freezes the prescaler and mtime while high (bus writes still land).
module clint_timer #(
  parameter int NUM_HARTS = 1,
  parameter int MTIME_DIV = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
`ifdef CLINT_MTIME_HALT_EN
  input  logic                 mtime_halt,
`endif
  clint_timer_if.slave         bus,
  output logic [63:0]          mtime,
  output logic [NUM_HARTS-1:0] timer_int,
  output logic [NUM_HARTS-1:0] soft_int,
  output logic [NUM_HARTS-1:0] timer_int_clear,
  output logic [NUM_HARTS-1:0] soft_int_clear
);

  localparam int              PW         = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(MTIME_DIV - 1);
  localparam int              CMP_BASE   = 'h800;     // 0x4000 in 8-byte units
  localparam logic [13:0]     MTIME_LO_W = 14'h2FFE;  // 0xBFF8 in word units
  localparam logic [13:0]     MTIME_HI_W = 14'h2FFF;  // 0xBFFC in word units

  typedef enum logic {IDLE, RESP} state_e;

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [15:2]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic                 write_q, write_d;
  logic [63:0]          mtime_q, mtime_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [63:0]          mtimecmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [NUM_HARTS-1:0] tint_q, tint_d;
  logic [NUM_HARTS-1:0] tclr_q, tclr_d;
  logic [NUM_HARTS-1:0] sclr_q, sclr_d;
  logic [31:0]          rd_val;
  logic                 halt;
  logic                 commit;
  logic                 inc;

`ifdef CLINT_MTIME_HALT_EN
  assign halt = mtime_halt;
`else
  assign halt = 1'b0;
`endif

  // Replace only the bytes selected by be, keep the rest of the old word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Read mux on the live request address; sampled into rdata when captured.
  always_comb begin
    rd_val = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (bus.addr[15:2] == 14'(h)) begin
        rd_val = {31'd0, msip_q[h]};
      end
      if (bus.addr[15:3] == 13'(CMP_BASE + h)) begin
        rd_val = bus.addr[2] ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
      end
    end
    if (bus.addr[15:2] == MTIME_LO_W) rd_val = mtime_q[31:0];
    if (bus.addr[15:2] == MTIME_HI_W) rd_val = mtime_q[63:32];
  end

  // Bus FSM: capture a request in IDLE, answer and commit in RESP, then back to IDLE.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (bus.ren | bus.wen) begin
          state_d = RESP;
          busy_d  = 1'b0;
          addr_d  = bus.addr[15:2];
          wdata_d = bus.wdata;
          be_d    = bus.byte_en;
          write_d = bus.wen;
          rdata_d = bus.wen ? 32'd0 : rd_val;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b1;
      end
    endcase
  end

  assign commit = (state_q == RESP) && write_q && (be_q != 4'd0);
  assign inc    = (presc_q == PRESC_MAX) && !halt;

  // Timer, register writes, compare and clear-pulse generation for the next cycle.
  always_comb begin
    presc_d    = halt ? presc_q : (inc ? '0 : presc_q + 1'b1);
    mtime_d    = mtime_q + {63'd0, inc};
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    if (commit) begin
      if (addr_q == MTIME_LO_W) begin
        mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_q, be_q)};
        presc_d = '0;
      end
      if (addr_q == MTIME_HI_W) begin
        mtime_d = {merge_bytes(mtime_q[63:32], wdata_q, be_q), mtime_q[31:0]};
        presc_d = '0;
      end
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (addr_q == 14'(h) && be_q[0]) begin
          msip_d[h] = wdata_q[0];
        end
        if (addr_q[15:3] == 13'(CMP_BASE + h)) begin
          if (addr_q[2]) begin
            mtimecmp_d[h][63:32] = merge_bytes(mtimecmp_q[h][63:32], wdata_q, be_q);
          end else begin
            mtimecmp_d[h][31:0] = merge_bytes(mtimecmp_q[h][31:0], wdata_q, be_q);
          end
        end
      end
    end
    tint_d = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      tint_d[h] = (mtime_d >= mtimecmp_d[h]);
    end
    tclr_d = tint_q & ~tint_d;
    sclr_d = msip_q & ~msip_d;
  end

  // State registers; reset drops any pending write and suppresses clear pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      busy_q  <= 1'b1;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      mtime_q <= '0;
      presc_q <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= '1;
      end
      msip_q  <= '0;
      tint_q  <= '0;
      tclr_q  <= '0;
      sclr_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      write_q    <= write_d;
      mtime_q    <= mtime_d;
      presc_q    <= presc_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      tint_q     <= tint_d;
      tclr_q     <= tclr_d;
      sclr_q     <= sclr_d;
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign mtime           = mtime_q;
  assign timer_int       = tint_q;
  assign soft_int        = msip_q;
  assign timer_int_clear = tclr_q;
  assign soft_int_clear  = sclr_q;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: scoreboard bench for clint_timer (NUM_HARTS=2, MTIME_DIV=4).
// mtime is modelled as base + elapsed_edges/DIV from the last write or reset.
module tb_clint_timer;

  localparam int NH  = 2;
  localparam int DIV = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
`ifdef CLINT_MTIME_HALT_EN
  logic mtime_halt = 1'b0;
`endif

  clint_timer_if bus();
  logic [63:0]   mtime;
  logic [NH-1:0] timer_int, soft_int, timer_int_clear, soft_int_clear;

  clint_timer #(.NUM_HARTS(NH), .MTIME_DIV(DIV)) dut (
    .CLK             (CLK),
    .RST             (RST),
`ifdef CLINT_MTIME_HALT_EN
    .mtime_halt      (mtime_halt),
`endif
    .bus             (bus),
    .mtime           (mtime),
    .timer_int       (timer_int),
    .soft_int        (soft_int),
    .timer_int_clear (timer_int_clear),
    .soft_int_clear  (soft_int_clear)
  );

  always #5 CLK = ~CLK;

  // Count rising edges; read at #1 after an edge or at the falling edge.
  longint cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [63:0]   m_base;
  longint        m_base_edge;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip;
  bit            model_valid = 1'b0;
  logic [31:0]   exp_q [$];
  logic [NH-1:0] prev_ti, prev_ms, ti_exp;
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic logic [63:0] model_mtime(longint n);
    return m_base + 64'((n - m_base_edge) / DIV);
  endfunction

  function automatic logic [31:0] tb_merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] model_read(logic [15:0] a, longint n);
    int w;
    logic [63:0] t;
    w = int'({a[15:2], 2'b00});
    t = model_mtime(n);
    if (w < 4 * NH) return {31'd0, m_msip[w / 4]};
    if (w >= 'h4000 && w < 'h4000 + 8 * NH)
      return (w % 8 == 4) ? m_cmp[(w - 'h4000) / 8][63:32] : m_cmp[(w - 'h4000) / 8][31:0];
    if (w == 'hBFF8) return t[31:0];
    if (w == 'hBFFC) return t[63:32];
    return 32'd0;
  endfunction

  function automatic void model_commit(logic [15:0] a, logic [31:0] d, logic [3:0] be, longint e);
    int w;
    int h;
    logic [63:0] cur;
    w = int'({a[15:2], 2'b00});
    if (be == 4'd0) return;
    if (w < 4 * NH) begin
      if (be[0]) m_msip[w / 4] = d[0];
    end else if (w >= 'h4000 && w < 'h4000 + 8 * NH) begin
      h = (w - 'h4000) / 8;
      if (w % 8 == 4) m_cmp[h][63:32] = tb_merge(m_cmp[h][63:32], d, be);
      else            m_cmp[h][31:0]  = tb_merge(m_cmp[h][31:0], d, be);
    end else if (w == 'hBFF8 || w == 'hBFFC) begin
      cur = model_mtime(e - 1);
      if (w == 'hBFF8) cur[31:0]  = tb_merge(cur[31:0], d, be);
      else             cur[63:32] = tb_merge(cur[63:32], d, be);
      m_base      = cur;
      m_base_edge = e;
    end
  endfunction

  function automatic void model_reset(longint e);
    m_base      = '0;
    m_base_edge = e;
    for (int h = 0; h < NH; h++) m_cmp[h] = '1;
    m_msip      = '0;
    model_valid = 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Reset for two edges; leaves the caller #1 after the last reset edge.
  task automatic applyReset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset(cyc);
    exp_q.delete();
    checkOutput("reset_busy", 64'(bus.busy), 64'd1);
    checkOutput("reset_rdata", 64'(bus.rdata), 64'd0);
    checkOutput("reset_mtime", mtime, 64'd0);
    checkOutput("reset_timer_int", 64'(timer_int), 64'd0);
  endtask

  // One bus transaction, entered and left #1 after an edge with the DUT idle.
  // With abort set, RST is raised during the response cycle instead of committing.
  task automatic applyStimulus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                               input bit r, input bit w, input bit abort);
    exp_q.push_back(w ? 32'd0 : model_read(a, cyc));
    bus.addr    = a;
    bus.wdata   = d;
    bus.byte_en = be;
    bus.ren     = r;
    bus.wen     = w;
    @(posedge CLK);
    #1;
    checkOutput("resp_latency_busy", 64'(bus.busy), 64'd0);
    bus.ren     = 1'b0;
    bus.wen     = 1'b0;
    bus.addr    = 16'($urandom);
    bus.wdata   = $urandom;
    bus.byte_en = 4'($urandom);
    if (abort) begin
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset(cyc);
      checkOutput("abort_busy", 64'(bus.busy), 64'd1);
      checkOutput("abort_clear_pulses", 64'({timer_int_clear, soft_int_clear}), 64'd0);
    end else begin
      @(posedge CLK);
      #1;
      if (w) model_commit(a, d, be, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard on every response and checks timer outputs each cycle.
  always @(negedge CLK) begin
    if (bus.busy === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_response: got rdata 0x%0h, expected no response", bus.rdata);
      end else begin
        checkOutput("rdata", 64'(bus.rdata), 64'(exp_q.pop_front()));
      end
    end
    if (RST) begin
      prev_ti = '0;
      prev_ms = '0;
    end else if (model_valid) begin
      for (int h = 0; h < NH; h++) ti_exp[h] = (model_mtime(cyc) >= m_cmp[h]);
      checkOutput("mtime", mtime, model_mtime(cyc));
      checkOutput("timer_int", 64'(timer_int), 64'(ti_exp));
      checkOutput("timer_int_clear", 64'(timer_int_clear), 64'(prev_ti & ~ti_exp));
      checkOutput("soft_int", 64'(soft_int), 64'(m_msip));
      checkOutput("soft_int_clear", 64'(soft_int_clear), 64'(prev_ms & ~m_msip));
      prev_ti = ti_exp;
      prev_ms = m_msip;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [63:0] now;
  logic [15:0] ra;
  int          kind;
  int          h;
  logic [15:0] rd_addrs [12];

  initial begin
    bus.addr = '0; bus.wdata = '0; bus.byte_en = '0; bus.ren = 1'b0; bus.wen = 1'b0;
    rd_addrs = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                 16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'h8000, 16'hBFF4};

    applyReset();
    idle(10);
    applyStimulus(16'h4000, 32'd0, 4'hF, 1'b1, 1'b0, 1'b0);

    // mtimecmp[0] a little ahead of mtime, let it fire, then push it away
    applyStimulus(16'h4004, 32'd0, 4'hF, 1'b0, 1'b1, 1'b0);
    now = model_mtime(cyc);
    applyStimulus(16'h4000, now[31:0] + 32'd20, 4'hF, 1'b0, 1'b1, 1'b0);
    idle(100);
    checkOutput("timer_fired", 64'(timer_int[0]), 64'd1);
    now = model_mtime(cyc);
    applyStimulus(16'h4000, now[31:0] + 32'd1000, 4'hF, 1'b0, 1'b1, 1'b0);
    idle(3);

    // software interrupt for hart 1: set, set again, clear
    applyStimulus(16'h0004, 32'd1, 4'hF, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h0004, 32'd1, 4'hF, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h0004, 32'd0, 4'hF, 1'b0, 1'b1, 1'b0);
    idle(2);

    // lo carry into hi, byte-enable write, combined ren/wen, unmapped read
    applyStimulus(16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'hBFFC, 32'd0, 4'hF, 1'b0, 1'b1, 1'b0);
    idle(6);
    applyStimulus(16'hBFFC, 32'd0, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'hBFF8, 32'h1234_56AB, 4'b0001, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'hBFF8, 32'd5, 4'hF, 1'b1, 1'b1, 1'b0);
    applyStimulus(16'h8000, 32'd0, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'hBFF8, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1, 1'b0);

    // mtime wrap from all-ones
    applyStimulus(16'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 1'b0);
    idle(10);

    // reset during the response of a mtimecmp[0] write
    applyStimulus(16'h4000, 32'd5, 4'hF, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'h4000, 32'd0, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h4004, 32'd0, 4'hF, 1'b1, 1'b0, 1'b0);

`ifdef CLINT_MTIME_HALT_EN
    now = model_mtime(cyc);
    mtime_halt = 1'b1;
    repeat (8) begin
      @(posedge CLK);
      #1;
      m_base_edge = m_base_edge + 1;
    end
    mtime_halt = 1'b0;
    checkOutput("halt_mtime_frozen", mtime, now);
`endif

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      h    = $urandom_range(0, NH - 1);
      now  = model_mtime(cyc);
      case (kind)
        0: applyStimulus(16'($urandom_range(0, NH) * 4), $urandom, 4'($urandom_range(0, 15)),
                         1'b0, 1'b1, 1'b0);
        1, 2: begin
          if ($urandom_range(0, 3) == 0)
            applyStimulus(16'('h4004 + 8 * h), now[63:32] + 32'($urandom_range(0, 1)),
                          4'hF, 1'b0, 1'b1, 1'b0);
          else
            applyStimulus(16'('h4000 + 8 * h), now[31:0] + 32'($urandom_range(0, 40)),
                          ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF, 1'b0, 1'b1, 1'b0);
        end
        3: applyStimulus(($urandom_range(0, 1) == 0) ? 16'hBFF8 : 16'hBFFC, $urandom,
                         4'($urandom), 1'b0, 1'b1, 1'b0);
        8: begin
          ra = 16'h8000 | 16'($urandom);
          applyStimulus(ra, $urandom, 4'hF, 1'($urandom), 1'b1, 1'b0);
        end
        9: applyStimulus(rd_addrs[$urandom_range(0, 11)], $urandom, 4'($urandom),
                         1'b1, 1'b1, 1'b0);
        default: begin
          ra = rd_addrs[$urandom_range(0, 11)] | 16'($urandom_range(0, 3));
          applyStimulus(ra, $urandom, 4'hF, 1'b1, 1'b0, 1'b0);
        end
      endcase
      idle($urandom_range(0, 3));
    end

    idle(4);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
